// File: rtl/fa4_fetch_unit.sv
// fa4_fetch_unit: instruction fetch stage of the FA4 4-bit CPU.
//
// This block owns the program counter and runs the multiplexed 4-bit
// program-memory bus. Each fetch drives ADDR_NIBBLES address nibbles,
// least significant first, and then reads two opcode nibbles (opr, opa).
// The assembled 8-bit instruction sits in a one-entry buffer and is
// handed to decode over a valid/ready handshake.
//
// Ports:
//   clock        system clock; all state changes on the rising edge
//   reset_n      asynchronous, active-low reset
//   fetch_en     allows a new fetch to start (sampled in A1 only)
//   jump_en      redirect pulse; has the highest priority
//   jump_addr    redirect target
//   data_in      nibble returned by program memory during M1/M2
//   addr_out     address nibble driven onto the memory bus
//   sync_out     marks the first address phase of a fetch
//   mem_rd       high while memory must drive data_in
//   instr        buffered instruction {opr, opa}
//   instr_pc     address the buffered instruction came from
//   instr_valid  the buffer holds an instruction
//   instr_ready  decode accepts the instruction this cycle
//   pc_out       current program counter, used for stack pushes
module fa4_fetch_unit #(
    parameter int                      ADDR_NIBBLES = 3,
    parameter logic [4*ADDR_NIBBLES-1:0] RESET_PC   = '0
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      fetch_en,
    input  logic                      jump_en,
    input  logic [4*ADDR_NIBBLES-1:0] jump_addr,
    input  logic [3:0]                data_in,
    output logic [3:0]                addr_out,
    output logic                      sync_out,
    output logic                      mem_rd,
    output logic [7:0]                instr,
    output logic [4*ADDR_NIBBLES-1:0] instr_pc,
    output logic                      instr_valid,
    input  logic                      instr_ready,
    output logic [4*ADDR_NIBBLES-1:0] pc_out
);

    localparam int PCW = 4 * ADDR_NIBBLES;
    localparam int CW  = (ADDR_NIBBLES > 1) ? $clog2(ADDR_NIBBLES) : 1;
    localparam logic [CW-1:0] LAST_NIB = CW'(ADDR_NIBBLES - 1);

    // All address phases share one state; nib_cnt_reg tells A1/A2/A3 apart.
    localparam logic [1:0] ST_ADDR = 2'd0;
    localparam logic [1:0] ST_M1   = 2'd1;
    localparam logic [1:0] ST_M2   = 2'd2;
    localparam logic [1:0] ST_WAIT = 2'd3;

    logic [1:0]     state_reg;
    logic [CW-1:0]  nib_cnt_reg;
    logic [PCW-1:0] pc_reg;
    logic [3:0]     opr_reg;
    logic [3:0]     opa_reg;
    logic [7:0]     instr_reg;
    logic [PCW-1:0] instr_pc_reg;
    logic           instr_valid_reg;

    logic           in_a1;
    logic           buf_free;
    logic           xfer;

    // Split the PC into its address nibbles for the bus mux.
    logic [3:0] pc_nib [ADDR_NIBBLES];
    genvar gi;
    generate
        for (gi = 0; gi < ADDR_NIBBLES; gi++) begin : g_nib
            assign pc_nib[gi] = pc_reg[4*gi +: 4];
        end
    endgenerate

    assign in_a1    = (state_reg == ST_ADDR) && (nib_cnt_reg == '0);
    assign xfer     = instr_valid_reg && instr_ready;
    // The buffer can take a new word if it is empty or is being drained now.
    assign buf_free = !instr_valid_reg || instr_ready;

    always_comb begin
        addr_out = 4'h0;
        if (state_reg == ST_ADDR) begin
            addr_out = pc_nib[nib_cnt_reg];
        end
    end

    assign sync_out    = in_a1 && fetch_en;
    assign mem_rd      = (state_reg == ST_M1) || (state_reg == ST_M2);
    assign pc_out      = pc_reg;
    assign instr       = instr_reg;
    assign instr_pc    = instr_pc_reg;
    assign instr_valid = instr_valid_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= ST_ADDR;
            nib_cnt_reg     <= '0;
            pc_reg          <= RESET_PC;
            opr_reg         <= 4'h0;
            opa_reg         <= 4'h0;
            instr_reg       <= 8'h00;
            instr_pc_reg    <= '0;
            instr_valid_reg <= 1'b0;
        end else if (jump_en) begin
            // Redirect wins over everything: the partial fetch, any word
            // parked in WAIT and the buffer contents are all dropped.
            state_reg       <= ST_ADDR;
            nib_cnt_reg     <= '0;
            pc_reg          <= jump_addr;
            instr_valid_reg <= 1'b0;
        end else begin
            // Default handshake: a taken word leaves the buffer empty
            // unless a new one is loaded below.
            if (xfer) begin
                instr_valid_reg <= 1'b0;
            end

            case (state_reg)
                ST_ADDR: begin
                    // fetch_en only gates leaving A1; later phases always run.
                    if (in_a1 && !fetch_en) begin
                        nib_cnt_reg <= '0;
                    end else if (nib_cnt_reg == LAST_NIB) begin
                        nib_cnt_reg <= '0;
                        state_reg   <= ST_M1;
                    end else begin
                        nib_cnt_reg <= nib_cnt_reg + CW'(1);
                    end
                end
                ST_M1: begin
                    opr_reg   <= data_in;
                    state_reg <= ST_M2;
                end
                ST_M2: begin
                    if (buf_free) begin
                        instr_reg       <= {opr_reg, data_in};
                        instr_pc_reg    <= pc_reg;
                        instr_valid_reg <= 1'b1;
                        pc_reg          <= pc_reg + PCW'(1);
                        state_reg       <= ST_ADDR;
                    end else begin
                        opa_reg   <= data_in;
                        state_reg <= ST_WAIT;
                    end
                end
                default: begin // ST_WAIT: buffer is full, hold the word
                    if (xfer) begin
                        instr_reg       <= {opr_reg, opa_reg};
                        instr_pc_reg    <= pc_reg;
                        instr_valid_reg <= 1'b1;
                        pc_reg          <= pc_reg + PCW'(1);
                        state_reg       <= ST_ADDR;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fa4_fetch_unit.sv
// Directed testbench for fa4_fetch_unit (default parameters: 12-bit PC,
// RESET_PC = 0). Inputs change 1 time unit after the rising edge and
// outputs are checked there, well away from the next edge.
module tb_fa4_fetch_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        fetch_en;
    logic        jump_en;
    logic [11:0] jump_addr;
    logic [3:0]  data_in;
    logic [3:0]  addr_out;
    logic        sync_out;
    logic        mem_rd;
    logic [7:0]  instr;
    logic [11:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [11:0] pc_out;

    int n_cmp = 0;
    int n_err = 0;

    fa4_fetch_unit dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .fetch_en    (fetch_en),
        .jump_en     (jump_en),
        .jump_addr   (jump_addr),
        .data_in     (data_in),
        .addr_out    (addr_out),
        .sync_out    (sync_out),
        .mem_rd      (mem_rd),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc_out      (pc_out)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        fetch_en    = 1'b0;
        jump_en     = 1'b0;
        jump_addr   = 12'h000;
        data_in     = 4'h0;
        instr_ready = 1'b1;

        // ---- reset state ----
        #12;
        check("rst_pc", pc_out, 12'h000);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_instr", instr, 8'h00);
        check("rst_instr_pc", instr_pc, 12'h000);
        check("rst_mem_rd", mem_rd, 1'b0);
        check("rst_addr", addr_out, 4'h0);
        check("rst_sync_off", sync_out, 1'b0);
        fetch_en = 1'b1;
        #1;
        check("rst_sync_on", sync_out, 1'b1);
        reset_n = 1'b1;

        // ---- first fetch from 000: A1 A2 A3 M1 M2 ----
        tick();                                   // A2
        check("f1_a2_addr", addr_out, 4'h0);
        check("f1_a2_sync", sync_out, 1'b0);
        check("f1_a2_memrd", mem_rd, 1'b0);
        tick();                                   // A3
        check("f1_a3_addr", addr_out, 4'h0);
        tick();                                   // M1
        check("f1_m1_memrd", mem_rd, 1'b1);
        check("f1_m1_addr", addr_out, 4'h0);
        data_in = 4'hA;
        tick();                                   // M2
        check("f1_m2_memrd", mem_rd, 1'b1);
        check("f1_m2_valid", instr_valid, 1'b0);
        data_in = 4'h3;
        tick();                                   // A1 of fetch 2
        $display("fetch 1: instr=%h instr_pc=%h", instr, instr_pc);
        check("f1_valid", instr_valid, 1'b1);
        check("f1_instr", instr, 8'hA3);
        check("f1_instr_pc", instr_pc, 12'h000);
        check("f1_pc", pc_out, 12'h001);
        check("f2_a1_addr", addr_out, 4'h1);
        check("f2_a1_sync", sync_out, 1'b1);

        // ---- second fetch from 001, buffer drained by ready=1 ----
        tick();                                   // A2
        check("f2_a2_addr", addr_out, 4'h0);
        check("f2_drained", instr_valid, 1'b0);
        tick();                                   // A3
        check("f2_a3_addr", addr_out, 4'h0);
        tick();                                   // M1
        data_in = 4'h5;
        tick();                                   // M2
        data_in = 4'hC;
        tick();                                   // A1
        $display("fetch 2: instr=%h instr_pc=%h", instr, instr_pc);
        check("f2_instr", instr, 8'h5C);
        check("f2_instr_pc", instr_pc, 12'h001);
        check("f2_pc", pc_out, 12'h002);

        // ---- backpressure: ready low, third fetch parks in WAIT ----
        instr_ready = 1'b0;
        tick(); tick(); tick();                   // A2 A3 M1
        data_in = 4'h7;
        tick();                                   // M2
        data_in = 4'h8;
        tick();                                   // WAIT
        check("bp_instr", instr, 8'h5C);
        check("bp_instr_pc", instr_pc, 12'h001);
        check("bp_valid", instr_valid, 1'b1);
        check("bp_pc", pc_out, 12'h002);
        check("bp_memrd", mem_rd, 1'b0);
        check("bp_sync", sync_out, 1'b0);
        tick(); tick();                           // still WAIT
        check("bp_hold_instr", instr, 8'h5C);
        check("bp_hold_pc", pc_out, 12'h002);
        instr_ready = 1'b1;
        tick();                                   // held word loaded, A1
        instr_ready = 1'b0;
        $display("fetch 3: instr=%h instr_pc=%h", instr, instr_pc);
        check("bp_rel_valid", instr_valid, 1'b1);
        check("bp_rel_instr", instr, 8'h78);
        check("bp_rel_instr_pc", instr_pc, 12'h002);
        check("bp_rel_pc", pc_out, 12'h003);
        check("bp_rel_sync", sync_out, 1'b1);

        // ---- wrap: jump to FFF (also drops buffered word) ----
        jump_en   = 1'b1;
        jump_addr = 12'hFFF;
        tick();
        jump_en = 1'b0;
        check("wr_jmp_valid", instr_valid, 1'b0);
        check("wr_jmp_pc", pc_out, 12'hFFF);
        check("wr_a1_addr", addr_out, 4'hF);
        instr_ready = 1'b1;
        tick();                                   // A2
        check("wr_a2_addr", addr_out, 4'hF);
        tick();                                   // A3
        check("wr_a3_addr", addr_out, 4'hF);
        tick();                                   // M1
        data_in = 4'h9;
        tick();                                   // M2
        data_in = 4'h1;
        tick();                                   // A1 at 000
        $display("fetch 4: instr=%h instr_pc=%h", instr, instr_pc);
        check("wr_instr", instr, 8'h91);
        check("wr_instr_pc", instr_pc, 12'hFFF);
        check("wr_pc", pc_out, 12'h000);
        check("wr_n_a1", addr_out, 4'h0);
        tick();                                   // A2
        check("wr_n_a2", addr_out, 4'h0);
        tick();                                   // A3
        check("wr_n_a3", addr_out, 4'h0);
        tick();                                   // M1

        // ---- jump during M1 aborts the fetch ----
        check("jm1_memrd", mem_rd, 1'b1);
        jump_en   = 1'b1;
        jump_addr = 12'h2B4;
        data_in   = 4'hD;
        tick();
        jump_en = 1'b0;
        check("jm1_valid", instr_valid, 1'b0);
        check("jm1_memrd_off", mem_rd, 1'b0);
        check("jm1_pc", pc_out, 12'h2B4);
        check("jm1_a1_addr", addr_out, 4'h4);
        check("jm1_sync", sync_out, 1'b1);
        tick();
        check("jm1_a2_addr", addr_out, 4'hB);
        tick();
        check("jm1_a3_addr", addr_out, 4'h2);
        tick();                                   // M1
        data_in = 4'hE;
        tick();                                   // M2
        data_in = 4'h6;
        tick();                                   // A1 at 2B5
        $display("fetch 5: instr=%h instr_pc=%h", instr, instr_pc);
        check("jm1_instr", instr, 8'hE6);
        check("jm1_instr_pc", instr_pc, 12'h2B4);

        // ---- jump coinciding with a transfer at M2 end ----
        instr_ready = 1'b0;
        check("jm2_a1_addr", addr_out, 4'h5);
        tick(); tick(); tick();                   // A2 A3 M1
        data_in = 4'h0;
        tick();                                   // M2
        check("jm2_valid_before", instr_valid, 1'b1);
        data_in     = 4'hF;
        instr_ready = 1'b1;
        jump_en     = 1'b1;
        jump_addr   = 12'h123;
        tick();
        jump_en = 1'b0;
        check("jm2_valid", instr_valid, 1'b0);
        check("jm2_pc", pc_out, 12'h123);
        check("jm2_addr", addr_out, 4'h3);

        // ---- fetch_en low parks in A1 ----
        fetch_en = 1'b0;
        #1;
        check("fe0_sync", sync_out, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("fe0_memrd", mem_rd, 1'b0);
            check("fe0_sync_loop", sync_out, 1'b0);
        end
        check("fe0_pc", pc_out, 12'h123);
        check("fe0_addr", addr_out, 4'h3);

        // ---- drop fetch_en during A2: fetch still completes ----
        fetch_en = 1'b1;
        #1;
        check("fe_sync", sync_out, 1'b1);
        tick();                                   // A2
        fetch_en = 1'b0;
        check("fe_a2_addr", addr_out, 4'h2);
        tick();                                   // A3
        check("fe_a3_addr", addr_out, 4'h1);
        tick();                                   // M1
        data_in = 4'h4;
        tick();                                   // M2
        data_in = 4'hD;
        tick();                                   // A1 at 124, parked
        $display("fetch 6: instr=%h instr_pc=%h", instr, instr_pc);
        check("fe_valid", instr_valid, 1'b1);
        check("fe_instr", instr, 8'h4D);
        check("fe_instr_pc", instr_pc, 12'h123);
        check("fe_pc", pc_out, 12'h124);
        check("fe_sync_off", sync_out, 1'b0);

        // ---- asynchronous reset in A3 with a full buffer ----
        instr_ready = 1'b0;
        fetch_en    = 1'b1;
        tick();                                   // A2
        tick();                                   // A3
        check("ar_a3_addr", addr_out, 4'h1);
        check("ar_valid_before", instr_valid, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_pc", pc_out, 12'h000);
        check("ar_valid", instr_valid, 1'b0);
        check("ar_instr", instr, 8'h00);
        check("ar_instr_pc", instr_pc, 12'h000);
        check("ar_addr", addr_out, 4'h0);
        check("ar_memrd", mem_rd, 1'b0);
        check("ar_sync", sync_out, 1'b1);
        #4;
        reset_n = 1'b1;
        tick();                                   // A2 after restart
        check("ar_restart_addr", addr_out, 4'h0);
        check("ar_restart_sync", sync_out, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fa4_fetch_unit.md
Name: fa4_fetch_unit

Overview:
- Instruction fetch stage of the FA4 4-bit CPU. Sits directly upstream of the instruction register and decode logic.
- Owns the program counter and drives the multiplexed 4-bit program-memory bus: three address nibbles out, then two opcode nibbles in.
- Holds each assembled 8-bit instruction in a one-entry output buffer and hands it to decode over a valid/ready handshake.
- Accepts jump/branch redirects from the control path.

Parameters:
ADDR_NIBBLES, 3, number of address nibbles per fetch; PC width is 4*ADDR_NIBBLES (12 bits by default)
RESET_PC, 0, PC value after reset (width 4*ADDR_NIBBLES)

Ports:
clock  input  1  system clock; all state updates on the rising edge
reset_n  input  1  asynchronous, active-low reset
fetch_en  input  1  allow a new fetch cycle to start
jump_en  input  1  redirect request, single-cycle pulse
jump_addr  input  12  redirect target
data_in  input  4  nibble returned by program memory
addr_out  output  4  address nibble driven onto the memory bus
sync_out  output  1  marks the first address phase (A1)
mem_rd  output  1  high while memory must drive data_in (M1, M2)
instr  output  8  buffered instruction, {opr, opa}
instr_pc  output  12  address the buffered instruction was fetched from
instr_valid  output  1  output buffer holds an instruction
instr_ready  input  1  decode accepts the instruction this cycle
pc_out  output  12  current PC, used for stack pushes

Behaviour:
- States: A1, A2, A3, M1, M2, WAIT. The A-phase count follows ADDR_NIBBLES, using an internal nibble counter.
- Reset (asynchronous, immediate):
  - state=A1, pc=RESET_PC.
  - instr_valid=0, instr=0, instr_pc=0.
  - Any in-progress fetch is discarded.
- Combinational outputs:
  - addr_out = pc[3:0] in A1, pc[7:4] in A2, pc[11:8] in A3, 0 otherwise.
  - sync_out = (state==A1 && fetch_en).
  - mem_rd = (state==M1 || state==M2).
  - pc_out = pc.
  - After reset: addr_out=RESET_PC[3:0], sync_out=fetch_en, mem_rd=0, instr_valid=0.
- Transitions:
  - A1 stays in A1 while fetch_en=0. fetch_en only gates the start of a fetch; a fetch already started always completes.
  - A1→A2→A3→M1→M2, one cycle each.
  - M1: latch data_in as opr (upper nibble).
  - M2: latch data_in as opa (lower nibble).
  - End of M2, buffer free (instr_valid=0, or instr_valid && instr_ready this cycle):
    - load instr={opr,data_in}, instr_pc=pc, instr_valid=1;
    - pc <= pc+1;
    - go to A1.
  - End of M2, buffer full and not accepted: go to WAIT, holding the assembled instruction.
  - WAIT: when instr_ready is seen with instr_valid=1, load the held instruction into the buffer (instr_valid stays 1), pc <= pc+1, go to A1.
- Latency and throughput:
  - instr_valid rises on the clock edge ending M2.
  - Throughput is one instruction per 5 cycles with ready held high.
- Handshake:
  - A transfer occurs when instr_valid && instr_ready on a rising edge.
  - If no new instruction is loaded that edge, instr_valid clears.
  - instr and instr_pc are stable while instr_valid=1 and not accepted.
- PC arithmetic: modulo 2^(4*ADDR_NIBBLES); 12'hFFF+1 = 12'h000, no flag raised.
- Jump (jump_en=1 on an edge) has highest priority:
  - pc <= jump_addr, state <= A1;
  - instr_valid <= 0 and any held (WAIT) instruction is dropped;
  - any partial fetch is aborted.
  - If instr_valid && instr_ready in the same cycle, that transfer counts as completed; a jump coinciding with M2 end still discards the just-fetched instruction.
  - A jump while fetch_en=0 still updates pc.
- Reset asserted mid-fetch aborts the fetch immediately. Memory must tolerate a truncated cycle; the next sync_out marks the new cycle.

Test Plan:
- Reset → pc_out=000, instr_valid=0. Release with fetch_en=1, instr_ready=1, memory returning 4'hA then 4'h3 → addr_out sequence 0,0,0; instr_valid at cycle 5 with instr=8'hA3, instr_pc=000; second fetch shows addr_out=1,0,0.
- Backpressure: hold instr_ready=0 across two fetches → first instruction stays stable, FSM parks in WAIT, pc unchanged. Raise ready for 1 cycle → second instruction appears the next cycle and pc advances by 1.
- Wrap: jump_addr=12'hFFF, fetch one instruction → instr_pc=FFF, next addr_out nibbles 0,0,0.
- jump_en=1 with jump_addr=12'h2B4 during M1 → fetch aborted, no instr_valid; next cycle A1 with addr_out=4,B,2 and sync_out=1.
- jump_en coincident with instr_valid&&instr_ready at M2 end → buffer empty next cycle, pc=jump_addr.
- fetch_en=0 at A1 for 10 cycles → sync_out=0, no memory reads. Drop fetch_en during A2 → fetch completes and delivers its instruction. Assert reset_n=0 during A3 → outputs return to reset values asynchronously.
